// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the divider
// Holds the divider FSM state encoding and default operand width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - combinational adder/subtractor
// y = a - b when sub is 1, otherwise a + b; wraps modulo 2**WIDTH.
module add_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - self-sequencing radix-2 non-restoring divider
// Optional two's-complement operands when DIV_SIGNED_EN is defined.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   d;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             zero;

  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_y;
  logic             add_op;

`ifdef DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg      = signed_mode & dividend[WIDTH-1];
  assign dvs_neg      = signed_mode & divisor[WIDTH-1];
  assign abs_dividend = dvd_neg ? -dividend : dividend;
  assign abs_divisor  = dvs_neg ? -divisor : divisor;
  assign q_out        = neg_q ? -q : q;
  assign r_out        = neg_r ? -rem_mag : rem_mag;
`else
  logic signed_mode_unused;

  assign signed_mode_unused = signed_mode;
  assign abs_dividend       = dividend;
  assign abs_divisor        = divisor;
  assign q_out              = q;
  assign r_out              = rem_mag;
`endif

  // One adder serves both the CALC iteration and the FIX restore step.
  assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};

  always_comb begin
    add_a  = p_sh;
    add_op = ~p[WIDTH];
    if (state == FIX) begin
      add_a  = p;
      add_op = 1'b0;
    end
  end

  add_sub #(WIDTH + 1) u_add_sub (
    .a   (add_a),
    .b   (d),
    .sub (add_op),
    .y   (add_y)
  );

  assign rem_mag = p[WIDTH] ? add_y[WIDTH-1:0] : p[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      p           <= '0;
      d           <= '0;
      q           <= '0;
      cnt         <= '0;
      zero        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            d           <= {1'b0, abs_divisor};
            p           <= '0;
            // A zero divisor skips CALC; FIX publishes the raw dividend held in q.
            if (divisor == '0) begin
              q     <= dividend;
              zero  <= 1'b1;
              state <= FIX;
            end else begin
              q     <= abs_dividend;
              zero  <= 1'b0;
              cnt   <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= CALC;
            end
`ifdef DIV_SIGNED_EN
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          p   <= add_y;
          q   <= {q[WIDTH-2:0], ~add_y[WIDTH]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= q_out;
            remainder <= r_out;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
